sensor_log_writer: RTL and testbench
====================================

Name: sensor_log_writer

Overview:
- Upstream producer for the 1024x32 on-chip data memory; an Avalon-MM write-only master on the same interconnect as the Nios.
- Accepts timestamped sensor samples (temperature, humidity, soil, light channels) over a valid/ready stream.
- Writes each sample as a 2-word record into a circular log region, so software can read history without polling sensors.
- Exposes the write pointer, wrap count and stall count as status outputs for a CSR block.

Parameters:
- ADDR_W, 10, word-address width; matches the 1024-word memory.
- DEPTH_WORDS, 1024, log region size in words; must be even and at most 2**ADDR_W.
- TS_W, 28, timestamp counter width; header word = {channel[3:0], timestamp[27:0]}.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  logging enable; sampled only in IDLE.
- clear  in  1  one-cycle pulse: zero the pointer, counters and timestamp.
- snk_valid  in  1  sample valid.
- snk_ready  out  1  sample accepted when snk_valid && snk_ready.
- snk_data  in  32  raw sample value.
- snk_channel  in  4  sensor channel id.
- avm_address  out  ADDR_W  word address.
- avm_byteenable  out  4  always 4'hF while avm_write=1, else 0.
- avm_chipselect  out  1  equals avm_write.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_waitrequest  in  1  slave stall.
- wr_ptr  out  ADDR_W  next record word address; always even.
- wrap_count  out  16  number of ring wraps; saturates at 16'hFFFF.
- stall_count  out  16  cycles with snk_valid && enable && !snk_ready; saturates.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: every output 0, state IDLE, timestamp 0, clear_pending 0. Reset mid-record abandons the transfer immediately; avm_write drops the following cycle edge.
- Timestamp: free-running TS_W-bit counter, +1 every clk, wraps to 0 naturally. Zeroed by reset or by an applied clear.
- snk_ready = (state==IDLE) && enable && !clear && !clear_pending.
- States:
  - IDLE: on accept, latch hdr={snk_channel, ts} and data=snk_data, then go to WR_HDR.
  - WR_HDR: avm_write=1, address=wr_ptr, writedata=hdr. Hold all master outputs stable while avm_waitrequest=1. On !waitrequest go to WR_DATA.
  - WR_DATA: address=wr_ptr+1, writedata=data, same hold rule. On !waitrequest: wr_ptr += 2, wrapping to 0 when the result equals DEPTH_WORDS (wrap_count +1 saturating). Return to IDLE.
- Latency: accept at edge N; header write visible N+1; data write N+2 at the earliest (zero wait states). Record throughput is 1 per 3 cycles minimum.
- clear in IDLE: applied the same cycle; the sample is not accepted (clear wins over snk_valid).
- clear while busy: sets clear_pending. The record in flight completes, and the clear is applied on entering IDLE, before any new accept.
- enable falling mid-record: the record still completes, with no further accepts.
- stall_count counts while a clear is pending and while busy. It does not count while enable=0.
- No address ever reaches DEPTH_WORDS; the header is always at an even address.

Decomposition:
- Shared package sensor_log_pkg holds:
  - the state enum {IDLE, WR_HDR, WR_DATA};
  - the header field constants HDR_CH_MSB=31, HDR_CH_LSB=28, HDR_TS_MSB=27;
  - the record size constant REC_WORDS=2.
- No sub-module; the timestamp and saturating counters stay inline.

Test Plan:
- Single sample after reset: ch=3, data=32'h0000_01A4, accepted at ts=5, no waitrequest -> writes addr0=32'h3000_0005, addr1=32'h0000_01A4; wr_ptr=2.
- Waitrequest hold: 3 cycles of waitrequest during WR_HDR -> address, writedata and write held constant for 4 cycles; data write follows; snk_ready=0 throughout.
- Wrap: preload with 512 records -> record 512 at addr 1022/1023, wr_ptr=0, wrap_count=1; record 513 written at addr 0.
- Back-to-back snk_valid held high for 10 cycles, zero wait -> 4 records accepted (cycles 0, 3, 6, 9); stall_count=6.
- clear in WR_HDR -> record completes at addr 2k/2k+1, then wr_ptr=0, counters=0, ts=0; next accept is blocked until the following cycle.
- reset asserted in WR_DATA -> next cycle avm_write=0 and all status outputs 0; the new first record is written at addr 0.

Source files
------------

// File: rtl/sensor_log_pkg.sv
// Shared types and header-layout constants for the sensor log writer.
package sensor_log_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_HDR  = 2'd1,
        WR_DATA = 2'd2
    } state_t;

    localparam int HDR_CH_MSB = 31;
    localparam int HDR_CH_LSB = 28;
    localparam int HDR_TS_MSB = 27;
    localparam int REC_WORDS  = 2;

endpackage

// File: rtl/sensor_log_writer_if.sv
// Sample stream (sink side) plus Avalon-MM write-only master signals.
interface sensor_log_writer_if #(
    parameter int ADDR_W = 10
);
    logic              snk_valid;
    logic              snk_ready;
    logic [31:0]       snk_data;
    logic [3:0]        snk_channel;
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_chipselect;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic              avm_waitrequest;

    modport master (
        input  snk_valid, snk_data, snk_channel, avm_waitrequest,
        output snk_ready, avm_address, avm_byteenable, avm_chipselect,
               avm_write, avm_writedata
    );

    modport slave (
        output snk_valid, snk_data, snk_channel, avm_waitrequest,
        input  snk_ready, avm_address, avm_byteenable, avm_chipselect,
               avm_write, avm_writedata
    );
endinterface

// File: rtl/sensor_log_writer.sv
// Writes timestamped samples as {hdr, data} word pairs into a circular memory log.
// Header write one cycle after accept, data write the next; master outputs hold under waitrequest.
module sensor_log_writer
    import sensor_log_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DEPTH_WORDS = 1024,
    parameter int TS_W        = 28
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear,
    sensor_log_writer_if.master bus,
    output logic [ADDR_W-1:0]   wr_ptr,
    output logic [15:0]         wrap_count,
    output logic [15:0]         stall_count,
    output logic                busy
);

    state_t            state, state_nxt;
    logic [TS_W-1:0]   ts;
    logic [31:0]       hdr_q, data_q, hdr_word;
    logic              clear_pending;
    logic              accept, clear_apply, rec_done, stall_evt;
    logic [ADDR_W:0]   ptr_sum;

    assign bus.snk_ready = (state == IDLE) && enable && !clear && !clear_pending;
    assign accept        = bus.snk_valid && bus.snk_ready;
    // A clear raised mid-record is held until the FSM is back in IDLE.
    assign clear_apply   = (state == IDLE) && (clear || clear_pending);
    assign rec_done      = (state == WR_DATA) && !bus.avm_waitrequest;
    assign stall_evt     = bus.snk_valid && enable && !bus.snk_ready;
    assign ptr_sum       = {1'b0, wr_ptr} + (ADDR_W+1)'(REC_WORDS);
    assign busy          = (state != IDLE);

    always_comb begin
        hdr_word = '0;
        hdr_word[HDR_CH_MSB:HDR_CH_LSB] = bus.snk_channel;
        hdr_word[HDR_TS_MSB:0]          = (HDR_TS_MSB+1)'(ts);
    end

    always_comb begin
        state_nxt          = state;
        bus.avm_write      = 1'b0;
        bus.avm_chipselect = 1'b0;
        bus.avm_byteenable = 4'h0;
        bus.avm_address    = '0;
        bus.avm_writedata  = '0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = WR_HDR;
            end
            WR_HDR: begin
                bus.avm_write      = 1'b1;
                bus.avm_chipselect = 1'b1;
                bus.avm_byteenable = 4'hF;
                bus.avm_address    = wr_ptr;
                bus.avm_writedata  = hdr_q;
                if (!bus.avm_waitrequest) state_nxt = WR_DATA;
            end
            WR_DATA: begin
                bus.avm_write      = 1'b1;
                bus.avm_chipselect = 1'b1;
                bus.avm_byteenable = 4'hF;
                bus.avm_address    = wr_ptr + ADDR_W'(1);
                bus.avm_writedata  = data_q;
                if (!bus.avm_waitrequest) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ts            <= '0;
            clear_pending <= 1'b0;
            wr_ptr        <= '0;
            wrap_count    <= '0;
            stall_count   <= '0;
            hdr_q         <= '0;
            data_q        <= '0;
        end else begin
            state <= state_nxt;
            if (clear_apply) begin
                ts            <= '0;
                clear_pending <= 1'b0;
                wr_ptr        <= '0;
                wrap_count    <= '0;
                stall_count   <= '0;
            end else begin
                ts <= ts + TS_W'(1);
                if (clear) clear_pending <= 1'b1;
                if (rec_done) begin
                    if (ptr_sum == (ADDR_W+1)'(DEPTH_WORDS)) begin
                        wr_ptr <= '0;
                        if (wrap_count != 16'hFFFF) wrap_count <= wrap_count + 16'd1;
                    end else begin
                        wr_ptr <= ptr_sum[ADDR_W-1:0];
                    end
                end
                if (stall_evt && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
            end
            if (accept) begin
                hdr_q  <= hdr_word;
                data_q <= bus.snk_data;
            end
        end
    end

endmodule

// File: tb/tb_sensor_log_writer.sv
// Scoreboarded bench: expected memory writes are queued at accept and retired on each completed write.
module tb_sensor_log_writer;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset, enable, clear;
    logic [ADDR_W-1:0] wr_ptr;
    logic [15:0]       wrap_count, stall_count;
    logic              busy;

    sensor_log_writer_if #(.ADDR_W(ADDR_W)) bus();

    sensor_log_writer #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .TS_W(28)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .clear       (clear),
        .bus         (bus),
        .wr_ptr      (wr_ptr),
        .wrap_count  (wrap_count),
        .stall_count (stall_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    wr_t               exp_q[$];
    int                checks = 0;
    int                errors = 0;
    int                accepts = 0;
    logic [27:0]       tb_ts;
    logic [ADDR_W-1:0] exp_ptr;
    logic [15:0]       exp_wrap;
    logic              ts_zero = 1'b0;
    logic [31:0]       h;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Model of the edge that follows each negedge: retire writes, queue accepted records.
    always @(negedge clk) begin
        wr_t w;
        if (reset) begin
            exp_q.delete();
            tb_ts    <= '0;
            exp_ptr  <= '0;
            exp_wrap <= '0;
        end else begin
            if (bus.avm_write && !bus.avm_waitrequest) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(bus.avm_address), 32'hFFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.avm_address), 32'(w.addr));
                    chk("wr_data", bus.avm_writedata, w.data);
                    chk("wr_be_cs", {27'd0, bus.avm_chipselect, bus.avm_byteenable}, 32'h1F);
                end
            end
            if (bus.snk_valid && bus.snk_ready) begin
                exp_q.push_back({exp_ptr, bus.snk_channel, tb_ts});
                exp_q.push_back({ADDR_W'(exp_ptr + ADDR_W'(1)), bus.snk_data});
                accepts <= accepts + 1;
                if (int'(exp_ptr) + 2 == DEPTH) begin
                    exp_ptr  <= '0;
                    exp_wrap <= exp_wrap + 16'd1;
                end else begin
                    exp_ptr <= exp_ptr + ADDR_W'(2);
                end
            end
            if (ts_zero) begin
                tb_ts    <= '0;
                exp_ptr  <= '0;
                exp_wrap <= '0;
            end else begin
                tb_ts <= tb_ts + 28'd1;
            end
        end
    end

    // Returns #1 after the accepting edge; hdr is the header the sample should carry.
    task automatic send(input logic [3:0] ch, input logic [31:0] d, output logic [31:0] hdr);
        int n = 0;
        bus.snk_channel = ch;
        bus.snk_data    = d;
        bus.snk_valid   = 1'b1;
        @(negedge clk);
        while (!bus.snk_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", 32'(bus.snk_ready), 32'd1);
        hdr = {ch, tb_ts};
        @(posedge clk);
        #1 bus.snk_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        reset = 1'b1; enable = 1'b0; clear = 1'b0;
        bus.snk_valid = 1'b0; bus.snk_data = '0; bus.snk_channel = '0;
        bus.avm_waitrequest = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
        chk("rst_counts", {wrap_count, stall_count}, 32'd0);
        chk("rst_busy_write", {30'd0, busy, bus.avm_write}, 32'd0);
        chk("rst_ready", 32'(bus.snk_ready), 32'd0);
        reset = 1'b0;
        enable = 1'b1;

        // Single sample accepted at ts=5
        repeat (5) @(posedge clk);
        #1 send(4'd3, 32'h0000_01A4, h);
        @(negedge clk);
        chk("t1_hdr_addr", 32'(bus.avm_address), 32'd0);
        chk("t1_hdr_data", bus.avm_writedata, 32'h3000_0005);
        @(negedge clk);
        chk("t1_dat_addr", 32'(bus.avm_address), 32'd1);
        chk("t1_dat_data", bus.avm_writedata, 32'h0000_01A4);
        wait_idle();
        chk("t1_wr_ptr", 32'(wr_ptr), 32'd2);

        // Three waitrequest cycles during the header write
        @(posedge clk);
        #1 bus.avm_waitrequest = 1'b1;
        send(4'd5, 32'hDEAD_BEEF, h);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_hold_wr", 32'(bus.avm_write), 32'd1);
            chk("t2_hold_addr", 32'(bus.avm_address), 32'd2);
            chk("t2_hold_data", bus.avm_writedata, h);
            chk("t2_hold_ready", 32'(bus.snk_ready), 32'd0);
            @(posedge clk);
            #1;
            if (i == 2) bus.avm_waitrequest = 1'b0;
        end
        @(negedge clk);
        chk("t2_dat_addr", 32'(bus.avm_address), 32'd3);
        chk("t2_dat_ready", 32'(bus.snk_ready), 32'd0);
        wait_idle();
        chk("t2_wr_ptr", 32'(wr_ptr), 32'd4);

        // Clear in IDLE beats a simultaneous valid
        @(posedge clk);
        #1 clear = 1'b1; ts_zero = 1'b1;
        bus.snk_valid = 1'b1; bus.snk_channel = 4'd1; bus.snk_data = 32'h77;
        @(negedge clk);
        chk("t3_clear_blocks", 32'(bus.snk_ready), 32'd0);
        @(posedge clk);
        #1 clear = 1'b0; ts_zero = 1'b0;
        chk("t3_clr_ptr", 32'(wr_ptr), 32'd0);
        chk("t3_clr_counts", {wrap_count, stall_count}, 32'd0);

        // Back-to-back valid for 10 cycles
        n0 = accepts;
        for (int i = 0; i < 10; i++) begin
            bus.snk_data = 32'h100 + 32'(i);
            @(posedge clk);
            #1;
        end
        bus.snk_valid = 1'b0;
        wait_idle();
        chk("t4_accepts", 32'(accepts - n0), 32'd4);
        chk("t4_stall", 32'(stall_count), 32'd6);
        chk("t4_wr_ptr", 32'(wr_ptr), 32'd8);

        // Ring wrap after 512 records
        @(posedge clk);
        #1 clear = 1'b1; ts_zero = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0; ts_zero = 1'b0;
        for (int i = 0; i < 511; i++) send(4'(i), 32'(i) ^ 32'hA5A5_0000, h);
        wait_idle();
        chk("t5_ptr_pre", 32'(wr_ptr), 32'd1022);
        chk("t5_wrap_pre", 32'(wrap_count), 32'd0);
        @(posedge clk);
        #1 send(4'hE, 32'hCAFE_0512, h);
        wait_idle();
        chk("t5_ptr_wrap", 32'(wr_ptr), 32'd0);
        chk("t5_wrap", 32'(wrap_count), 32'd1);
        chk("t5_wrap_model", 32'(wrap_count), 32'(exp_wrap));
        @(posedge clk);
        #1 send(4'hF, 32'hCAFE_0513, h);
        wait_idle();
        chk("t5_ptr_post", 32'(wr_ptr), 32'd2);

        // Clear raised while in WR_HDR
        @(posedge clk);
        #1 send(4'd7, 32'h5555_AAAA, h);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        bus.snk_valid = 1'b1; bus.snk_channel = 4'd9; bus.snk_data = 32'h0BAD_F00D;
        @(posedge clk);
        #1 ts_zero = 1'b1;
        @(negedge clk);
        chk("t6_pending_blocks", 32'(bus.snk_ready), 32'd0);
        chk("t6_rec_done_ptr", 32'(wr_ptr), 32'd4);
        @(posedge clk);
        #1 ts_zero = 1'b0;
        chk("t6_clr_ptr", 32'(wr_ptr), 32'd0);
        chk("t6_clr_counts", {wrap_count, stall_count}, 32'd0);
        @(negedge clk);
        chk("t6_ready_after", 32'(bus.snk_ready), 32'd1);
        @(posedge clk);
        #1 bus.snk_valid = 1'b0;
        @(negedge clk);
        chk("t6_hdr_ts0", bus.avm_writedata, 32'h9000_0000);
        wait_idle();
        chk("t6_wr_ptr", 32'(wr_ptr), 32'd2);

        // Reset while in WR_DATA
        @(posedge clk);
        #1 send(4'd2, 32'h0000_ABCD, h);
        @(posedge clk);
        #1 reset = 1'b1; bus.avm_waitrequest = 1'b1;
        @(negedge clk);
        chk("t7_in_data", 32'(bus.avm_write), 32'd1);
        @(posedge clk);
        #1;
        chk("t7_write_drop", {bus.avm_write, bus.avm_chipselect, bus.avm_byteenable}, 32'd0);
        chk("t7_status", {wr_ptr, wrap_count[5:0], stall_count}, 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        reset = 1'b0; bus.avm_waitrequest = 1'b0;
        send(4'd4, 32'h0000_1234, h);
        wait_idle();
        chk("t7_wr_ptr", 32'(wr_ptr), 32'd2);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
